// File: rtl/rf_port_ctrl.sv
// Register-file port controller: drives both RF ports, serves operand reads with a
// one-cycle registered response, and buffers writebacks that drain through idle ports.
module rf_port_ctrl #(
  parameter int WB_DEPTH = 2,
  parameter int XLEN     = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            rd_req_valid_i,
  output logic            rd_req_ready_o,
  input  logic [4:0]      rs1_i,
  input  logic [4:0]      rs2_i,
  output logic            rd_rsp_valid_o,
  input  logic            rd_rsp_ready_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  input  logic            wb_valid_i,
  output logic            wb_ready_o,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic            rf_rw1_o,
  output logic [31:0]     rf_addr1_o,
  output logic [XLEN-1:0] rf_data1_o,
  input  logic [XLEN-1:0] rf_data1_i,
  output logic            rf_rw2_o,
  output logic [31:0]     rf_addr2_o,
  output logic [XLEN-1:0] rf_data2_o,
  input  logic [XLEN-1:0] rf_data2_i
);

  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(WB_DEPTH);

  logic [4:0]      r_wb_idx  [WB_DEPTH];
  logic [XLEN-1:0] r_wb_data [WB_DEPTH];
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic            r_rsp_valid;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;

  logic            w_not_full;
  logic            w_rd_acc;
  logic            w_wb_acc;
  logic            w_push;
  logic            w_drain;
  logic            w_two;
  logic [CW-1:0]   w_pop;
  logic [PW-1:0]   w_slot0;
  logic [PW-1:0]   w_slot1;
  logic            w_hit1;
  logic            w_hit2;
  logic [XLEN-1:0] w_fwd1;
  logic [XLEN-1:0] w_fwd2;
  logic [XLEN-1:0] w_op1;
  logic [XLEN-1:0] w_op2;

  // Operand value as architecturally visible at acceptance, x0 hardwired to zero.
  function automatic logic [XLEN-1:0] sel_operand(
    input logic [4:0]      idx,
    input logic            push,
    input logic [4:0]      wb_rd,
    input logic [XLEN-1:0] wb_data,
    input logic            hit,
    input logic [XLEN-1:0] fwd,
    input logic [XLEN-1:0] rf_data
  );
    logic [XLEN-1:0] v;
    if (idx == 5'd0) begin
      v = {XLEN{1'b0}};
    end else if (push && (wb_rd == idx)) begin
      v = wb_data;
    end else if (hit) begin
      v = fwd;
    end else begin
      v = rf_data;
    end
    return v;
  endfunction

  // Handshakes are refused while reset is asserted so every output reads zero.
  assign w_not_full     = (r_count < DEPTH_C);
  assign wb_ready_o     = rst_ni & w_not_full;
  assign rd_req_ready_o = rst_ni & (~r_rsp_valid | rd_rsp_ready_i) & w_not_full;

  assign w_rd_acc = rd_req_valid_i & rd_req_ready_o;
  assign w_wb_acc = wb_valid_i & wb_ready_o;
  assign w_push   = w_wb_acc & (wb_rd_i != 5'd0);
  assign w_drain  = rst_ni & ~w_rd_acc & (r_count != {CW{1'b0}});
  assign w_two    = (r_count >= CW'(2));
  assign w_pop    = w_drain ? (w_two ? CW'(2) : CW'(1)) : CW'(0);
  assign w_slot0  = r_rd_ptr;
  assign w_slot1  = r_rd_ptr + PW'(1);

  assign rd_rsp_valid_o = r_rsp_valid;
  assign rs1_data_o     = r_rs1_data;
  assign rs2_data_o     = r_rs2_data;

  // Youngest buffered value per source index; later slots overwrite earlier hits.
  always_comb begin
    logic [PW-1:0] v_slot;
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    w_fwd1 = {XLEN{1'b0}};
    w_fwd2 = {XLEN{1'b0}};
    v_slot = {PW{1'b0}};
    for (int i = 0; i < WB_DEPTH; i++) begin
      v_slot = r_rd_ptr + PW'(i);
      if ((CW'(i) < r_count) && (r_wb_idx[v_slot] == rs1_i)) begin
        w_hit1 = 1'b1;
        w_fwd1 = r_wb_data[v_slot];
      end else begin
        w_hit1 = w_hit1;
      end
      if ((CW'(i) < r_count) && (r_wb_idx[v_slot] == rs2_i)) begin
        w_hit2 = 1'b1;
        w_fwd2 = r_wb_data[v_slot];
      end else begin
        w_hit2 = w_hit2;
      end
    end
  end

  assign w_op1 = sel_operand(rs1_i, w_push, wb_rd_i, wb_data_i, w_hit1, w_fwd1, rf_data1_i);
  assign w_op2 = sel_operand(rs2_i, w_push, wb_rd_i, wb_data_i, w_hit2, w_fwd2, rf_data2_i);

  // Port steering: reads win; otherwise drain the two oldest entries.
  always_comb begin
    rf_rw1_o   = 1'b0;
    rf_addr1_o = 32'd0;
    rf_data1_o = {XLEN{1'b0}};
    rf_rw2_o   = 1'b0;
    rf_addr2_o = 32'd0;
    rf_data2_o = {XLEN{1'b0}};
    if (w_rd_acc) begin
      rf_addr1_o = {27'd0, rs1_i};
      rf_addr2_o = {27'd0, rs2_i};
    end else if (w_drain) begin
      if (w_two && (r_wb_idx[w_slot0] == r_wb_idx[w_slot1])) begin
        // Older write is dead; only the younger reaches the RF.
        rf_rw1_o   = 1'b1;
        rf_addr1_o = {27'd0, r_wb_idx[w_slot1]};
        rf_data1_o = r_wb_data[w_slot1];
      end else begin
        rf_rw1_o   = 1'b1;
        rf_addr1_o = {27'd0, r_wb_idx[w_slot0]};
        rf_data1_o = r_wb_data[w_slot0];
        if (w_two) begin
          rf_rw2_o   = 1'b1;
          rf_addr2_o = {27'd0, r_wb_idx[w_slot1]};
          rf_data2_o = r_wb_data[w_slot1];
        end else begin
          rf_rw2_o   = 1'b0;
        end
      end
    end else begin
      rf_rw1_o = 1'b0;
    end
  end

  // Write buffer storage, pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < WB_DEPTH; i++) begin
        r_wb_idx[i]  <= 5'd0;
        r_wb_data[i] <= {XLEN{1'b0}};
      end
      r_rd_ptr <= {PW{1'b0}};
      r_wr_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_wb_idx[r_wr_ptr]  <= wb_rd_i;
        r_wb_data[r_wr_ptr] <= wb_data_i;
      end else begin
        r_wb_idx[r_wr_ptr]  <= r_wb_idx[r_wr_ptr];
      end
      r_wr_ptr <= r_wr_ptr + (w_push ? PW'(1) : PW'(0));
      r_rd_ptr <= r_rd_ptr + w_pop[PW-1:0];
      r_count  <= r_count - w_pop + (w_push ? CW'(1) : CW'(0));
    end
  end

  // Response register: capture on accept, hold until consumed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp_valid <= 1'b0;
      r_rs1_data  <= {XLEN{1'b0}};
      r_rs2_data  <= {XLEN{1'b0}};
    end else if (w_rd_acc) begin
      r_rsp_valid <= 1'b1;
      r_rs1_data  <= w_op1;
      r_rs2_data  <= w_op2;
    end else if (rd_rsp_ready_i) begin
      r_rsp_valid <= 1'b0;
    end else begin
      r_rsp_valid <= r_rsp_valid;
    end
  end

endmodule

// File: tb/tb_rf_port_ctrl.sv
// Bench for rf_port_ctrl: architectural register model plus write-buffer queue,
// checked every negedge, with directed vectors and hand-computed expectations.
module tb_rf_port_ctrl;

  localparam int WB_DEPTH = 2;
  localparam int XLEN     = 32;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic            rd_req_valid_i;
  logic            rd_req_ready_o;
  logic [4:0]      rs1_i;
  logic [4:0]      rs2_i;
  logic            rd_rsp_valid_o;
  logic            rd_rsp_ready_i;
  logic [XLEN-1:0] rs1_data_o;
  logic [XLEN-1:0] rs2_data_o;
  logic            wb_valid_i;
  logic            wb_ready_o;
  logic [4:0]      wb_rd_i;
  logic [XLEN-1:0] wb_data_i;
  logic            rf_rw1_o;
  logic [31:0]     rf_addr1_o;
  logic [XLEN-1:0] rf_data1_o;
  logic [XLEN-1:0] rf_data1_i;
  logic            rf_rw2_o;
  logic [31:0]     rf_addr2_o;
  logic [XLEN-1:0] rf_data2_o;
  logic [XLEN-1:0] rf_data2_i;

  rf_port_ctrl #(.WB_DEPTH(WB_DEPTH), .XLEN(XLEN)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .rd_req_valid_i(rd_req_valid_i), .rd_req_ready_o(rd_req_ready_o),
    .rs1_i(rs1_i), .rs2_i(rs2_i),
    .rd_rsp_valid_o(rd_rsp_valid_o), .rd_rsp_ready_i(rd_rsp_ready_i),
    .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .wb_valid_i(wb_valid_i), .wb_ready_o(wb_ready_o),
    .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
    .rf_rw1_o(rf_rw1_o), .rf_addr1_o(rf_addr1_o), .rf_data1_o(rf_data1_o), .rf_data1_i(rf_data1_i),
    .rf_rw2_o(rf_rw2_o), .rf_addr2_o(rf_addr2_o), .rf_data2_o(rf_data2_o), .rf_data2_i(rf_data2_i)
  );

  always #5 clk = ~clk;

  // Register file array behind the two ports (x0 holds junk to prove hardwiring).
  logic [31:0] rf_mem [32];
  logic        rf_loaded = 1'b0;
  assign rf_data1_i = rf_mem[rf_addr1_o[4:0]];
  assign rf_data2_i = rf_mem[rf_addr2_o[4:0]];

  always @(posedge clk) begin
    if (!rf_loaded) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= 32'h0000_1000 + i;
      rf_mem[0] <= 32'hBAD0_BAD0;
      rf_mem[1] <= 32'h0000_0011;
      rf_mem[2] <= 32'h0000_0022;
      rf_loaded <= 1'b1;
    end else begin
      if (rf_rw1_o) rf_mem[rf_addr1_o[4:0]] <= rf_data1_o;
      if (rf_rw2_o) rf_mem[rf_addr2_o[4:0]] <= rf_data2_o;
    end
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: architectural register view plus pending-write queue.
  typedef struct { logic [4:0] idx; logic [31:0] data; } ent_t;
  ent_t        q[$];
  logic [31:0] arch [32];
  bit          m_rsp_valid = 1'b0;
  logic [31:0] m_rs1 = 32'd0;
  logic [31:0] m_rs2 = 32'd0;

  function automatic logic [31:0] arch_read(input logic [4:0] idx, input bit push);
    if (idx == 5'd0) return 32'd0;
    if (push && wb_rd_i == idx) return wb_data_i;
    return arch[idx];
  endfunction

  always @(negedge clk) begin : compare
    int   n;
    bit   full, e_wb_rdy, e_rd_rdy, rd_acc, wb_acc, push, drain;
    logic e_rw1, e_rw2;
    logic [31:0] e_a1, e_a2, e_d1, e_d2;
    if (!rst_ni) begin
      chk("rst_rsp_valid", rd_rsp_valid_o, 0);
      chk("rst_rs1_data", rs1_data_o, 0);
      chk("rst_rs2_data", rs2_data_o, 0);
      chk("rst_ports", {rf_rw1_o, rf_rw2_o, rf_addr1_o, rf_addr2_o}, 0);
      chk("rst_port_data", {rf_data1_o, rf_data2_o}, 0);
      chk("rst_readies", {rd_req_ready_o, wb_ready_o}, 0);
      q.delete();
      m_rsp_valid = 1'b0;
      m_rs1 = 32'd0;
      m_rs2 = 32'd0;
      for (int i = 0; i < 32; i++) arch[i] = rf_mem[i];
    end else begin
      n        = q.size();
      full     = (n >= WB_DEPTH);
      e_wb_rdy = !full;
      e_rd_rdy = (!m_rsp_valid || rd_rsp_ready_i) && !full;
      rd_acc   = rd_req_valid_i && e_rd_rdy;
      wb_acc   = wb_valid_i && e_wb_rdy;
      push     = wb_acc && (wb_rd_i != 5'd0);
      drain    = !rd_acc && (n > 0);
      e_rw1 = 1'b0; e_rw2 = 1'b0; e_a1 = 32'd0; e_a2 = 32'd0; e_d1 = 32'd0; e_d2 = 32'd0;
      if (rd_acc) begin
        e_a1 = {27'd0, rs1_i};
        e_a2 = {27'd0, rs2_i};
      end else if (drain) begin
        if (n >= 2 && q[0].idx == q[1].idx) begin
          e_rw1 = 1'b1; e_a1 = {27'd0, q[1].idx}; e_d1 = q[1].data;
        end else begin
          e_rw1 = 1'b1; e_a1 = {27'd0, q[0].idx}; e_d1 = q[0].data;
          if (n >= 2) begin
            e_rw2 = 1'b1; e_a2 = {27'd0, q[1].idx}; e_d2 = q[1].data;
          end
        end
      end
      chk("wb_ready", wb_ready_o, e_wb_rdy);
      chk("rd_req_ready", rd_req_ready_o, e_rd_rdy);
      chk("rsp_valid", rd_rsp_valid_o, m_rsp_valid);
      chk("rs1_data", rs1_data_o, m_rs1);
      chk("rs2_data", rs2_data_o, m_rs2);
      chk("port1", {rf_rw1_o, rf_addr1_o, rf_data1_o}, {e_rw1, e_a1, e_d1});
      chk("port2", {rf_rw2_o, rf_addr2_o, rf_data2_o}, {e_rw2, e_a2, e_d2});
      if (rd_acc) begin
        m_rsp_valid = 1'b1;
        m_rs1 = arch_read(rs1_i, push);
        m_rs2 = arch_read(rs2_i, push);
      end else if (rd_rsp_ready_i) begin
        m_rsp_valid = 1'b0;
      end
      if (drain) begin
        void'(q.pop_front());
        if (n >= 2) void'(q.pop_front());
      end
      if (push) begin
        q.push_back('{idx: wb_rd_i, data: wb_data_i});
        arch[wb_rd_i] = wb_data_i;
      end
    end
  end

  task automatic setv(input bit rv, input logic [4:0] a1, input logic [4:0] a2, input bit rr,
                      input bit wv, input logic [4:0] wrd, input logic [31:0] wd);
    rd_req_valid_i = rv; rs1_i = a1; rs2_i = a2; rd_rsp_ready_i = rr;
    wb_valid_i = wv; wb_rd_i = wrd; wb_data_i = wd;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0;
    setv(0, 0, 0, 1, 0, 0, 0);
    repeat (2) @(posedge clk);
    #2 rst_ni = 1'b1;
    #1;
    chk("post_reset_rsp_valid", rd_rsp_valid_o, 0);
    chk("post_reset_wb_ready", wb_ready_o, 1);
    chk("post_reset_rw", {rf_rw1_o, rf_rw2_o}, 0);
    step();

    // Plain read of x1/x2.
    setv(1, 1, 2, 1, 0, 0, 0); #1;
    chk("read_ports", {rf_rw1_o, rf_rw2_o, rf_addr1_o[4:0], rf_addr2_o[4:0]}, {2'b00, 5'd1, 5'd2});
    step();
    setv(0, 0, 0, 1, 0, 0, 0); #1;
    chk("read_rsp", {rd_rsp_valid_o, rs1_data_o, rs2_data_o}, {1'b1, 32'h11, 32'h22});
    chk("read_rw_after", {rf_rw1_o, rf_rw2_o}, 0);
    step();

    // Buffered forwarding of x5, then drain.
    setv(0, 0, 0, 1, 1, 5, 32'hDEAD); step();
    setv(1, 5, 1, 1, 0, 0, 0); #1;
    chk("fwd_no_drain", rf_rw1_o, 0);
    step();
    setv(0, 0, 0, 1, 0, 0, 0); #1;
    chk("fwd_rsp", {rs1_data_o, rs2_data_o}, {32'hDEAD, 32'h11});
    chk("fwd_drain", {rf_rw1_o, rf_addr1_o[4:0], rf_data1_o, rf_rw2_o}, {1'b1, 5'd5, 32'hDEAD, 1'b0});
    step();

    // Same-cycle forwarding and x0 writeback.
    setv(1, 7, 0, 1, 1, 7, 32'hA5); step();
    setv(0, 0, 0, 1, 0, 0, 0); #1;
    chk("same_cycle_rsp", {rs1_data_o, rs2_data_o}, {32'hA5, 32'h0});
    chk("same_cycle_drain", {rf_rw1_o, rf_addr1_o[4:0]}, {1'b1, 5'd7});
    step();
    setv(0, 0, 0, 1, 1, 0, 32'hFFFF); #1;
    chk("x0_wb_ready", wb_ready_o, 1);
    step();
    setv(0, 0, 0, 1, 0, 0, 0); #1;
    chk("x0_no_write", {rf_rw1_o, rf_rw2_o}, 0);
    step();

    // Same-index pair and full-buffer stall.
    setv(1, 3, 5, 1, 1, 3, 32'h1); step();
    setv(1, 8, 9, 1, 1, 3, 32'h2); step();
    setv(1, 4, 4, 1, 1, 8, 32'h80); #1;
    chk("full_readies", {rd_req_ready_o, wb_ready_o}, 0);
    chk("same_idx_drain", {rf_rw1_o, rf_addr1_o[4:0], rf_data1_o, rf_rw2_o}, {1'b1, 5'd3, 32'h2, 1'b0});
    chk("full_rsp", {rs1_data_o, rs2_data_o}, {32'h1008, 32'h1009});
    step();
    #1 chk("resume_ready", rd_req_ready_o, 1);
    step();
    setv(1, 8, 9, 1, 1, 9, 32'h90); step();
    setv(1, 8, 9, 1, 0, 0, 0); #1;
    chk("full2_readies", {rd_req_ready_o, wb_ready_o}, 0);
    chk("dual_drain", {rf_rw1_o, rf_addr1_o[4:0], rf_rw2_o, rf_addr2_o[4:0]}, {1'b1, 5'd8, 1'b1, 5'd9});
    chk("buf_fwd_rsp", {rs1_data_o, rs2_data_o}, {32'h80, 32'h90});
    step();
    #1 chk("resume2_ready", rd_req_ready_o, 1);
    step();

    // Consumer stall for three cycles, then reset mid-stall.
    setv(1, 1, 2, 0, 1, 10, 32'hAAAA); #1;
    chk("stall_ready", rd_req_ready_o, 0);
    chk("stall_rsp", {rd_rsp_valid_o, rs1_data_o, rs2_data_o}, {1'b1, 32'h80, 32'h90});
    step();
    setv(1, 1, 2, 0, 0, 0, 0); #1;
    chk("stall_drain", {rf_rw1_o, rf_addr1_o[4:0], rf_data1_o}, {1'b1, 5'd10, 32'hAAAA});
    chk("stall_hold1", {rd_rsp_valid_o, rs1_data_o, rs2_data_o}, {1'b1, 32'h80, 32'h90});
    step();
    #1;
    chk("stall_hold2", {rd_rsp_valid_o, rs1_data_o, rs2_data_o, rd_req_ready_o}, {1'b1, 32'h80, 32'h90, 1'b0});
    #1 rst_ni = 1'b0;
    #1;
    chk("async_reset_outs", {rd_rsp_valid_o, rs1_data_o, rs2_data_o, rf_rw1_o, rf_rw2_o,
                             rf_addr1_o, rf_addr2_o, rf_data1_o, rf_data2_o}, 0);
    @(posedge clk); #1;
    setv(0, 0, 0, 1, 0, 0, 0);
    #1 rst_ni = 1'b1;
    step();

    // Mixed directed vectors, checked by the model.
    setv(1, 10, 3, 1, 1, 12, 32'hC1); step();
    setv(1, 12, 12, 1, 1, 12, 32'hC2); step();
    setv(0, 0, 0, 1, 1, 13, 32'hD1); step();
    setv(1, 13, 12, 0, 1, 14, 32'hE1); step();
    setv(1, 14, 0, 0, 1, 0, 32'h0); step();
    setv(1, 14, 13, 1, 1, 15, 32'hF1); step();
    setv(0, 0, 0, 1, 1, 15, 32'hF2); step();
    setv(1, 15, 12, 1, 0, 0, 0); step();
    setv(0, 0, 0, 1, 0, 0, 0);
    repeat (6) step();

    for (int i = 1; i < 32; i++) chk("rf_final", rf_mem[i], arch[i]);
    chk("x0_untouched", rf_mem[0], 32'hBAD0_BAD0);
    chk("x15_final", rf_mem[15], 32'hF2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
